serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Parametrised, digit-serial successor to the single-bit half adder.
- Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, by reusing one DIGIT-bit adder slice across the operand.
- Valid/ready handshakes on input and output, so it can sit between registered producers and consumers in the datapath examples.
- Trades latency (WIDTH/DIGIT cycles) for area.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be ≥1.
- DIGIT, 1, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH and WIDTH % DIGIT == 0 (elaboration-time assertion).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer presents operands.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  operand A, sampled on accept.
- B  input  WIDTH  operand B, sampled on accept.
- Cin  input  1  carry-in, sampled on accept.
- out_valid  output  1  Sum/Cout valid.
- out_ready  input  1  consumer accepts result.
- Sum  output  WIDTH  A+B+Cin modulo 2^WIDTH.
- Cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- Reset (rst_n low, asynchronous, any time): state=IDLE, counter=0, operand/result registers=0, carry register=0.
  - Resulting outputs: in_ready=1, out_valid=0, Sum=0, Cout=0.
  - Reset mid-operation discards the operation; no partial result is ever presented.
- Derived constant: N = WIDTH/DIGIT; counter width = max(1, $clog2(N)).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - Accept when in_valid && in_ready at a clock edge: latch A, B; carry register ← Cin; counter ← 0; go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - in_ready=0, out_valid=0.
  - Each edge: slice adds digit[counter] of A and B plus carry register. Result digit written to Sum[counter*DIGIT +: DIGIT]; carry register ← slice carry-out; counter++.
  - On the edge where counter==N-1: go to DONE, Cout ← final carry.
  - A, B and Cin changing during RUN have no effect.
- DONE:
  - out_valid=1; Sum/Cout stable.
  - On out_valid && out_ready: go to IDLE.
  - in_ready stays 0 in DONE; no accept in the same cycle as result handoff, so the next accept is earliest one cycle later.
- Latency:
  - out_valid rises exactly N cycles after the accept edge.
  - Throughput is one operation per N+2 cycles with out_ready held high.
- Back-pressure: out_ready low holds DONE indefinitely with Sum/Cout unchanged.
- Sum and Cout are registered outputs; they hold the last result in IDLE until the next accept overwrites digits progressively.
- Arithmetic:
  - {Cout,Sum} = A + B + Cin, computed at WIDTH+1 bits.
  - Wrap-around is modulo 2^WIDTH, with overflow indicated only by Cout.
- DIGIT==WIDTH: N=1, single RUN cycle, latency 1.
- Combinational outputs: in_ready and out_valid are decoded from state only, with no combinational path from in_valid or out_ready.

Decomposition:
- Shared package adder_pkg:
  - State enum typedef (IDLE, RUN, DONE).
  - Helper function computing counter width from N.
- One natural sub-module: digit_adder, a parametrised DIGIT-bit ripple adder built from full-adder cells (a, b, cin → s, cout).
  - It is purely combinational and instantiated once.
  - It is also reusable as the parallel adder in later projects.
- FSM, counter and registers live in serial_adder.

Test Plan:
- Reset: assert rst_n=0 mid-RUN (WIDTH=8, DIGIT=1, after 3 RUN cycles) → out_valid=0, in_ready=1, Sum=0, Cout=0 immediately. After release, next op A=8'h0F, B=8'h01, Cin=0 → Sum=8'h10, Cout=0.
- Basic latency: WIDTH=8, DIGIT=1, A=8'hA5, B=8'h5A, Cin=1, out_ready=1 → out_valid exactly 8 cycles after accept. Sum=8'h00, Cout=1. in_ready=0 throughout RUN/DONE.
- Wrap/boundaries: A=8'hFF, B=8'h00, Cin=1 → Sum=8'h00, Cout=1. A=B=0, Cin=0 → Sum=0, Cout=0. A=B=8'h80, Cin=0 → Sum=8'h00, Cout=1.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid; change A/B/in_valid during RUN and DONE → Sum/Cout stable, no new accept. Drop out_ready to 1 → IDLE next cycle, in_ready=1.
- Parameter sweep (WIDTH=16, DIGIT=4 and WIDTH=8, DIGIT=8): A=16'h1234, B=16'hEDCC, Cin=0 → Sum=16'h0000, Cout=1, latency 4. 8-bit: A=8'h7F, B=8'h01 → Sum=8'h80, Cout=0, latency 1.
- Random back-to-back: 500 random operands with random in_valid/out_ready → each result matches reference A+B+Cin, results in order, no lost or duplicated transactions.

Source files
------------

// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
//   Shared definitions for the digit-serial adder family.
//   - state_e     : control states of serial_adder (IDLE, RUN, DONE)
//   - cnt_width() : width of the digit counter for N digits, never below 1
//   - full_add()  : one full-adder cell, returns {cout, s}
// ---------------------------------------------------------------------------
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A single-digit operand still needs a 1-bit counter so the port of the
  // counter register never collapses to zero width.
  function automatic int cnt_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

  // Full-adder cell: bit 1 is carry-out, bit 0 is sum.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
    logic s_s;
    logic c_s;
    s_s = a ^ b ^ cin;
    c_s = (a & b) | (a & cin) | (b & cin);
    return {c_s, s_s};
  endfunction

endpackage : adder_pkg

// File: rtl/digit_adder.sv
// ---------------------------------------------------------------------------
// digit_adder
//   Purely combinational DIGIT-bit ripple-carry adder built from full-adder
//   cells. Used as the shared slice of serial_adder and usable on its own as
//   a parallel adder.
// Ports:
//   a, b  in  [DIGIT-1:0]  addend digits
//   cin   in  1            carry into bit 0
//   s     out [DIGIT-1:0]  digit sum
//   cout  out 1            carry out of bit DIGIT-1
// ---------------------------------------------------------------------------
module digit_adder
  import adder_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout
);

  // c_s[i] is the carry into cell i; c_s[DIGIT] leaves the slice.
  logic [DIGIT:0] c_s;

  assign c_s[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    logic [1:0] fa_s;
    assign fa_s       = full_add(a[i], b[i], c_s[i]);
    assign s[i]       = fa_s[0];
    assign c_s[i + 1] = fa_s[1];
  end

  assign cout = c_s[DIGIT];

endmodule : digit_adder

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//   Digit-serial adder: computes {Cout, Sum} = A + B + Cin over WIDTH bits,
//   DIGIT bits per clock, reusing one digit_adder slice. Operands are taken
//   with a valid/ready handshake, the result is offered the same way.
//   Latency from accept to out_valid is N = WIDTH/DIGIT cycles.
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   producer presents A/B/Cin
//   in_ready   out  block can accept operands (IDLE only)
//   A, B       in   [WIDTH-1:0] operands, sampled on accept
//   Cin        in   carry-in, sampled on accept
//   out_valid  out  Sum/Cout valid (DONE only)
//   out_ready  in   consumer takes the result
//   Sum        out  [WIDTH-1:0] A+B+Cin modulo 2^WIDTH
//   Cout       out  carry out of bit WIDTH-1
// ---------------------------------------------------------------------------
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = cnt_width(N);
  // Bit offset of the current digit; largest value is WIDTH-DIGIT.
  localparam int OFF_W = $clog2(WIDTH + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [OFF_W-1:0] DIG_OFF  = OFF_W'(DIGIT);

  if ((WIDTH < 1) || (DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
    $error("serial_adder: need 1 <= DIGIT <= WIDTH and WIDTH %% DIGIT == 0");
  end

  state_e             state_r;
  state_e             state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic               carry_r;
  logic [WIDTH-1:0]   sum_r;
  logic               cout_r;
  logic               in_ready_r;
  logic               out_valid_r;

  logic               accept_s;
  logic               handoff_s;
  logic               last_s;
  logic [OFF_W-1:0]   off_s;
  logic [DIGIT-1:0]   a_dig_s;
  logic [DIGIT-1:0]   b_dig_s;
  logic [DIGIT-1:0]   slice_sum_s;
  logic               slice_cout_s;

  // Digit selection for the shared slice.
  assign last_s  = (cnt_r == CNT_LAST);
  assign off_s   = OFF_W'(cnt_r) * DIG_OFF;
  assign a_dig_s = a_r[off_s +: DIGIT];
  assign b_dig_s = b_r[off_s +: DIGIT];

  digit_adder #(
    .DIGIT (DIGIT)
  ) u_slice (
    .a    (a_dig_s),
    .b    (b_dig_s),
    .cin  (carry_r),
    .s    (slice_sum_s),
    .cout (slice_cout_s)
  );

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode and handshake qualifiers.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    handoff_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          accept_s    = 1'b1;
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (out_valid_r && out_ready) begin
          handoff_s   = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Handshake flags are registered copies of the next state, so they are a
  // pure function of the current state with no path from in_valid/out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= (state_nxt_s == IDLE);
      out_valid_r <= (state_nxt_s == DONE);
    end
  end

  // Operand capture, digit sequencing and progressive result write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= CNT_ZERO;
      sum_r   <= {WIDTH{1'b0}};
      cout_r  <= 1'b0;
    end else if (accept_s) begin
      a_r     <= A;
      b_r     <= B;
      carry_r <= Cin;
      cnt_r   <= CNT_ZERO;
    end else if (state_r == RUN) begin
      sum_r[off_s +: DIGIT] <= slice_sum_s;
      carry_r               <= slice_cout_s;
      if (last_s) begin
        cnt_r  <= CNT_ZERO;
        cout_r <= slice_cout_s;
      end else begin
        cnt_r  <= cnt_r + CNT_ONE;
      end
    end else begin
      // IDLE without accept, or DONE: the result is held stable.
      cnt_r <= cnt_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign Sum       = sum_r;
  assign Cout      = cout_r;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: WIDTH=8, DIGIT=1
  logic       iv0, ir0, ov0, or0, cin0, co0;
  logic [7:0] a0, b0, s0;
  // Instance 1: WIDTH=16, DIGIT=4
  logic        iv1, ir1, ov1, or1, cin1, co1;
  logic [15:0] a1, b1, s1;
  // Instance 2: WIDTH=8, DIGIT=8
  logic       iv2, ir2, ov2, or2, cin2, co2;
  logic [7:0] a2, b2, s2;

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .A(a0), .B(b0),
    .Cin(cin0), .out_valid(ov0), .out_ready(or0), .Sum(s0), .Cout(co0)
  );
  serial_adder #(.WIDTH(16), .DIGIT(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .A(a1), .B(b1),
    .Cin(cin1), .out_valid(ov1), .out_ready(or1), .Sum(s1), .Cout(co1)
  );
  serial_adder #(.WIDTH(8), .DIGIT(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .A(a2), .B(b2),
    .Cin(cin2), .out_valid(ov2), .out_ready(or2), .Sum(s2), .Cout(co2)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain WIDTH+1-bit addition; bit w of the result is Cout.
  function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b, input logic cin);
    return {1'b0, a} + {1'b0, b} + {16'h0000, cin};
  endfunction

  function automatic logic get_ir(input int d);
    case (d)
      0: return ir0;
      1: return ir1;
      default: return ir2;
    endcase
  endfunction

  function automatic logic get_ov(input int d);
    case (d)
      0: return ov0;
      1: return ov1;
      default: return ov2;
    endcase
  endfunction

  function automatic logic get_co(input int d);
    case (d)
      0: return co0;
      1: return co1;
      default: return co2;
    endcase
  endfunction

  function automatic logic [15:0] get_sum(input int d);
    case (d)
      0: return {8'h00, s0};
      1: return s1;
      default: return {8'h00, s2};
    endcase
  endfunction

  task automatic set_in(input int d, input logic v, input logic [15:0] a, input logic [15:0] b, input logic c);
    case (d)
      0: begin iv0 = v; a0 = a[7:0]; b0 = b[7:0]; cin0 = c; end
      1: begin iv1 = v; a1 = a;      b1 = b;      cin1 = c; end
      default: begin iv2 = v; a2 = a[7:0]; b2 = b[7:0]; cin2 = c; end
    endcase
  endtask

  task automatic set_or(input int d, input logic r);
    case (d)
      0: or0 = r;
      1: or1 = r;
      default: or2 = r;
    endcase
  endtask

  // One complete transaction: accept, latency count, result check, optional
  // back-pressure for 'hold' cycles, then return to IDLE.
  task automatic run_op(input int d, input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input int w, input int n, input int hold);
    logic [16:0] e;
    logic [15:0] mask;
    int cyc;
    e    = ref_add(a, b, cin);
    mask = (w == 16) ? 16'hFFFF : 16'h00FF;
    @(negedge clk);
    chk({tag, "_in_ready_idle"}, 32'(get_ir(d)), 32'd1);
    set_or(d, (hold == 0));
    set_in(d, 1'b1, a, b, cin);
    @(posedge clk);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!get_ov(d)) begin
        chk({tag, "_in_ready_run"}, 32'(get_ir(d)), 32'd0);
        set_in(d, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
      end
    end while (!get_ov(d) && cyc < 64);
    set_in(d, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
    chk({tag, "_latency"}, 32'(cyc - 1), 32'(n));
    chk({tag, "_sum"}, 32'(get_sum(d)), 32'(e[15:0] & mask));
    chk({tag, "_cout"}, 32'(get_co(d)), 32'(e[w]));
    chk({tag, "_in_ready_done"}, 32'(get_ir(d)), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(get_ov(d)), 32'd1);
      chk({tag, "_hold_ready"}, 32'(get_ir(d)), 32'd0);
      chk({tag, "_hold_sum"}, 32'(get_sum(d)), 32'(e[15:0] & mask));
      chk({tag, "_hold_cout"}, 32'(get_co(d)), 32'(e[w]));
      set_in(d, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
    end
    set_in(d, 1'b0, 16'h0000, 16'h0000, 1'b0);
    set_or(d, 1'b1);
    @(negedge clk);
    chk({tag, "_post_valid"}, 32'(get_ov(d)), 32'd0);
    chk({tag, "_post_ready"}, 32'(get_ir(d)), 32'd1);
  endtask

  initial begin
    logic [16:0] q[$];
    logic [16:0] e;
    logic        ir, ov, v, r, c;
    logic [7:0]  ra, rb;
    int          acc, got, cyc;

    iv0 = 1'b0; a0 = 8'h00; b0 = 8'h00; cin0 = 1'b0; or0 = 1'b1;
    iv1 = 1'b0; a1 = 16'h0000; b1 = 16'h0000; cin1 = 1'b0; or1 = 1'b1;
    iv2 = 1'b0; a2 = 8'h00; b2 = 8'h00; cin2 = 1'b0; or2 = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(ir0), 32'd1);
    chk("rst_out_valid", 32'(ov0), 32'd0);
    chk("rst_sum", 32'(s0), 32'd0);
    chk("rst_cout", 32'(co0), 32'd0);
    chk("rst_in_ready_w16", 32'(ir1), 32'd1);
    chk("rst_out_valid_w8d8", 32'(ov2), 32'd0);
    rst_n = 1'b1;

    // Basic latency and boundary operands, WIDTH=8 DIGIT=1
    run_op(0, "a5_5a", 16'h00A5, 16'h005A, 1'b1, 8, 8, 0);
    run_op(0, "ff_00", 16'h00FF, 16'h0000, 1'b1, 8, 8, 0);
    run_op(0, "zero",  16'h0000, 16'h0000, 1'b0, 8, 8, 0);
    run_op(0, "80_80", 16'h0080, 16'h0080, 1'b0, 8, 8, 0);
    // Back-pressure with inputs churning during RUN and DONE
    run_op(0, "bp",    16'h003C, 16'h00C5, 1'b1, 8, 8, 5);

    // Reset in the middle of RUN after three RUN cycles
    @(negedge clk);
    chk("mid_rst_idle", 32'(ir0), 32'd1);
    set_in(0, 1'b1, 16'h00FF, 16'h0000, 1'b0);
    @(posedge clk);
    @(negedge clk);
    set_in(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(ov0), 32'd0);
    chk("mid_rst_in_ready", 32'(ir0), 32'd1);
    chk("mid_rst_sum", 32'(s0), 32'd0);
    chk("mid_rst_cout", 32'(co0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, "after_rst", 16'h000F, 16'h0001, 1'b0, 8, 8, 0);

    // Parameter sweep
    run_op(1, "w16d4", 16'h1234, 16'hEDCC, 1'b0, 16, 4, 0);
    run_op(2, "w8d8",  16'h007F, 16'h0001, 1'b0, 8, 1, 0);
    run_op(2, "w8d8_bp", 16'h00FF, 16'h00FF, 1'b1, 8, 1, 2);

    // Random back-to-back traffic with random in_valid / out_ready
    acc = 0; got = 0; cyc = 0;
    while ((acc < 500 || q.size() != 0) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      ir = ir0;
      ov = ov0;
      v  = (acc < 500) ? ($urandom_range(0, 3) != 0) : 1'b0;
      r  = ($urandom_range(0, 3) != 0);
      ra = 8'($urandom);
      rb = 8'($urandom);
      c  = 1'($urandom);
      iv0 = v; a0 = ra; b0 = rb; cin0 = c; or0 = r;
      if (ov && r) begin
        if (q.size() == 0) begin
          chk("rand_unexpected_result", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("rand_sum", 32'(s0), 32'(e[7:0]));
          chk("rand_cout", 32'(co0), 32'(e[8]));
          got++;
        end
      end
      if (v && ir) begin
        q.push_back(ref_add({8'h00, ra}, {8'h00, rb}, c));
        acc++;
      end
    end
    iv0 = 1'b0;
    or0 = 1'b1;
    chk("rand_accepted", 32'(acc), 32'd500);
    chk("rand_results", 32'(got), 32'd500);
    chk("rand_pending", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_serial_adder
